// File: rtl/instr_fetch_pkg.sv
// Shared types and field positions for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int JIDX_MSB   = 25;
  localparam int IMM_MSB    = 15;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection for the held instruction: jump, taken branch, or fall-through.
module instr_fetch_next_pc
  import instr_fetch_pkg::*;
(
  input  logic [31:0]        pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               zero,
  output logic [31:0]        next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic        unused_opcode;

  // The opcode field does not take part in target arithmetic.
  assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  assign jump_target   = {pc_plus4[31:28], instr[JIDX_MSB:0], 2'b00};
  assign branch_offset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};

  // Jump outranks Branch; all sums wrap at 32 bits.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && zero) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding memory reads,
// and holds each fetched word until decode accepts it.
// Optional build macro FETCH_PERF_EN adds fetch_count / stall_count outputs.
//
// state | meaning
// REQ   | imem_req high for one cycle at imem_addr = pc
// WAIT  | waiting for imem_rvalid; first valid beat is captured
// HOLD  | instruction presented to decode until id_ready
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         func,
  output logic               instr_valid,
  input  logic               id_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               zero
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [31:0]        next_pc;
  logic               capture;
  logic               accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response arriving outside WAIT is stale and ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = HOLD;
      HOLD:    if (id_ready) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  // Output decode; the request is gated by reset so it stays low while held in reset.
  always_comb begin
    imem_req = rst_n & (state_q == REQ);
    capture  = (state_q == WAIT) & imem_rvalid;
    accept   = (state_q == HOLD) & id_ready;
  end

  // Datapath update: capture the word in WAIT, advance the PC on acceptance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (capture) begin
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end
    if (accept) begin
      pc_d    = next_pc;
      valid_d = 1'b0;
    end
  end

  // PC, instruction and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign func        = instr_q[FUNC_MSB:FUNC_LSB];

  instr_fetch_next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .Branch   (Branch),
    .Jump     (Jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Accepted responses and decode back-pressure cycles; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == HOLD) && !id_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard records the expected PC and
// word at each request and compares them when the DUT presents the instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        Branch, Jump, zero;

  logic        imem_req,  u2_imem_req;
  logic [31:0] imem_addr, u2_imem_addr;
  logic [31:0] instr,     u2_instr;
  logic [5:0]  opcode,    u2_opcode;
  logic [5:0]  func,      u2_func;
  logic        instr_valid, u2_instr_valid;
  logic [31:0] pc,        u2_pc;
  logic [31:0] pc_plus4,  u2_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, u2_fetch_count, u2_stall_count;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .opcode(opcode), .func(func), .instr_valid(instr_valid), .id_ready(id_ready),
    .pc(pc), .pc_plus4(pc_plus4), .Branch(Branch), .Jump(Jump), .zero(zero)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(u2_imem_req), .imem_addr(u2_imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(u2_instr),
    .opcode(u2_opcode), .func(u2_func), .instr_valid(u2_instr_valid), .id_ready(id_ready),
    .pc(u2_pc), .pc_plus4(u2_pc_plus4), .Branch(Branch), .Jump(Jump), .zero(zero)
`ifdef FETCH_PERF_EN
    , .fetch_count(u2_fetch_count), .stall_count(u2_stall_count)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  sb_t         sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  logic [31:0] exp_fetch = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] nxt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference next-PC written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input bit br, input bit j, input bit z);
    logic [31:0] p4;
    int          off;
    p4  = p + 32'd4;
    off = $signed(w[15:0]);
    if (j) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && z) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) check_eq("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  // One fetch: request observed, response after lat cycles, instruction checked.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word,
                           input int lat, input bit spurious, input bit rdy_early);
    sb_t e;
    wait_req();
    check_eq("req_addr", imem_addr, exp_addr);
    sb_q.push_back('{pc: exp_addr, word: word});
    if (spurious) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end
    id_ready = rdy_early;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check_eq("wait_no_req", {31'b0, imem_req}, 32'd0);
      check_eq("wait_invalid", {31'b0, instr_valid}, 32'd0);
      imem_rvalid = (i == lat);
      imem_rdata  = (i == lat) ? word : 32'h0;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    id_ready    = 1'b0;
    exp_fetch   = exp_fetch + 32'd1;
    check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("instr", instr, e.word);
      check_eq("pc", pc, e.pc);
      check_eq("pc_plus4", pc_plus4, e.pc + 32'd4);
      check_eq("opcode", {26'b0, opcode}, {26'b0, e.word[31:26]});
      check_eq("func", {26'b0, func}, {26'b0, e.word[5:0]});
      cur_pc    = e.pc;
      cur_instr = e.word;
    end
`ifdef FETCH_PERF_EN
    check_eq("fetch_count", fetch_count, exp_fetch);
`endif
  endtask

  // Hold for 'stall' cycles, then accept with the given control inputs.
  task automatic accept(input int stall, input bit br, input bit j, input bit z,
                        output logic [31:0] next_exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_no_req", {31'b0, imem_req}, 32'd0);
      check_eq("stall_instr", instr, cur_instr);
      check_eq("stall_pc", pc, cur_pc);
    end
    exp_stall = exp_stall + 32'(stall);
`ifdef FETCH_PERF_EN
    check_eq("stall_count", stall_count, exp_stall);
`endif
    next_exp = model_next(cur_pc, cur_instr, br, j, z);
    id_ready = 1'b1;
    Branch   = br;
    Jump     = j;
    zero     = z;
    @(negedge clk);
    id_ready = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    zero     = 1'b0;
    check_eq("accept_invalid", {31'b0, instr_valid}, 32'd0);
    check_eq("next_pc", pc, next_exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    zero        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    #1;

    // Sequential fetch at 0x0, 0x4, 0x8, 0xC.
    fetch_one(32'h0000_0000, 32'h2002_0005, 1, 0, 0);
    accept(0, 0, 0, 0, nxt);
    fetch_one(nxt, 32'h0043_0820, 1, 0, 0);
    accept(0, 0, 0, 0, nxt);
    fetch_one(nxt, 32'h8C44_0004, 1, 0, 0);
    accept(0, 0, 0, 0, nxt);
    fetch_one(nxt, 32'h0000_0000, 1, 0, 0);
    accept(0, 0, 0, 0, nxt);

    // Backward branch by -1 word from 0x10, then not-taken.
    fetch_one(32'h0000_0010, 32'h1000_FFFF, 1, 0, 0);
    accept(0, 1, 0, 1, nxt);
    fetch_one(32'h0000_0010, 32'h1000_FFFF, 1, 0, 0);
    accept(0, 1, 0, 0, nxt);

    // Jump to 0x100, then Jump wins over a taken branch.
    fetch_one(32'h0000_0014, 32'h0800_0040, 1, 0, 0);
    accept(0, 0, 1, 0, nxt);
    fetch_one(32'h0000_0100, 32'h0800_0040, 1, 0, 0);
    accept(0, 1, 1, 1, nxt);
    fetch_one(32'h0000_0100, 32'h1000_0003, 1, 0, 0);
    accept(0, 1, 0, 1, nxt);

    // Decode stalls five cycles.
    fetch_one(32'h0000_0110, 32'h0085_1022, 1, 0, 0);
    accept(5, 0, 0, 0, nxt);

    // Slow memory, stale rvalid in REQ, id_ready high while nothing is held.
    fetch_one(nxt, 32'hAC85_0008, 3, 1, 1);
    accept(2, 0, 0, 0, nxt);

    // Reset during WAIT with a late response.
    wait_req();
    check_eq("pre_rst_addr", imem_addr, nxt);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("wrap_rst_pc", u2_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb_q.delete();
    exp_fetch = 0;
    exp_stall = 0;
    check_eq("wrap_req", {31'b0, u2_imem_req}, 32'd1);
    check_eq("wrap_addr", u2_imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", u2_pc_plus4, 32'h0);
    fetch_one(32'h0000_0000, 32'h0000_0020, 1, 0, 0);
    check_eq("wrap_instr", u2_instr, 32'h0000_0020);
    check_eq("wrap_valid", {31'b0, u2_instr_valid}, 32'd1);
    accept(0, 0, 0, 0, nxt);
    check_eq("wrap_next_pc", u2_pc, 32'h0);
    check_eq("wrap_next_addr", u2_imem_addr, 32'h0);
    fetch_one(32'h0000_0004, 32'h2002_0001, 2, 0, 0);
    accept(1, 0, 0, 0, nxt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
